branch_pc_sequencer: RTL and testbench

//  Downstream consumer of the CON flip-flop. Owns the program counter and, for a

---
 rtl/branch_pc_sequencer_pkg.sv | 40 ++++
 rtl/branch_pc_sequencer_if.sv | 51 +++++
 rtl/branch_pc_sequencer_pc_reg.sv | 46 ++++
 rtl/branch_pc_sequencer.sv | 138 +++++++++++++
 tb/tb_branch_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pc_sequencer_pkg.sv
// Shared definitions for the branch PC sequencer.
// Holds the FSM state encoding, the instruction field bounds,
// the default branch opcode and the C2 sign-extension helper.
package branch_pc_sequencer_pkg;

  // Sequencer states.
  // A conditional branch always walks the full ring:
  // IDLE -> STROBE -> SETTLE -> RESOLVE -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RESOLVE = 2'd3
  } seq_state_e;

  // Opcode field of the instruction register.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  // C2 branch offset field of the instruction register.
  // Bit 18 is the sign bit.
  localparam int C2_HI = 18;
  localparam int C2_LO = 0;
  localparam int C2_W  = C2_HI - C2_LO + 1;

  // Opcode that identifies a conditional branch.
  localparam logic [OPC_W-1:0] BR_OPCODE_DEFAULT = 5'b10010;

  // Settle counter width.
  // It covers the full 1..7 range of CON_SETTLE.
  localparam int SETTLE_CNT_W = 3;

  // Sign-extend a C2 offset to 64 bits.
  // The caller truncates the result to the PC width it needs.
  function automatic logic [63:0] sext_c2(input logic [C2_W-1:0] c2);
    return {{(64 - C2_W){c2[C2_W-1]}}, c2};
  endfunction

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Control-unit / CON flip-flop interface of the branch PC sequencer.
// The master side drives requests and the CON flip-flop result.
// The slave side (the sequencer) returns the PC and the branch status.
interface branch_pc_sequencer_if #(
  parameter int PC_W = 32
);

  // Requests towards the sequencer.
  logic            start;
  logic [31:0]     instruction;
  logic            con_in;
  logic            pc_inc;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_value;

  // Responses from the sequencer.
  logic            con_strobe;
  logic [PC_W-1:0] pc_out;
  logic            busy;
  logic            done;
  logic            taken;

  modport master (
    output start,
    output instruction,
    output con_in,
    output pc_inc,
    output pc_load,
    output pc_load_value,
    input  con_strobe,
    input  pc_out,
    input  busy,
    input  done,
    input  taken
  );

  modport slave (
    input  start,
    input  instruction,
    input  con_in,
    input  pc_inc,
    input  pc_load,
    input  pc_load_value,
    output con_strobe,
    output pc_out,
    output busy,
    output done,
    output taken
  );

endinterface

// File: rtl/branch_pc_sequencer_pc_reg.sv
// Program counter register.
// Update priority is absolute load, then relative add, then increment.
// All arithmetic wraps modulo 2^PC_W.
module branch_pc_sequencer_pc_reg
  import branch_pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic            add_en,
  input  logic [PC_W-1:0] load_value,
  input  logic [PC_W-1:0] add_value,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next-PC selection: load beats add, and add beats increment.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (add_en) begin
      pc_d = pc_q + add_value;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // PC storage; reset returns to the boot address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Branch PC sequencer.
// It owns the program counter. For a conditional branch it pulses the CON
// flip-flop enable, waits CON_SETTLE cycles, then samples the CON result.
// When the branch is taken it adds the sign-extended C2 offset to the PC.
// Outside a branch it services the fetch-increment and absolute-load requests.
module branch_pc_sequencer
  import branch_pc_sequencer_pkg::*;
#(
  parameter int               PC_W       = 32,
  parameter logic [PC_W-1:0]  RESET_PC   = '0,
  parameter logic [OPC_W-1:0] BR_OPCODE  = BR_OPCODE_DEFAULT,
  parameter int               CON_SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active low
  branch_pc_sequencer_if.slave  bus
);

  // The counter counts down to zero, so CON_SETTLE cycles are spent in SETTLE.
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_INIT = SETTLE_CNT_W'(CON_SETTLE - 1);

  seq_state_e              state_q;
  seq_state_e              state_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt_d;
  logic [PC_W-1:0]         offset_q;
  logic [PC_W-1:0]         offset_d;
  logic                    taken_q;
  logic                    taken_d;

  logic                    br_hit;
  logic                    pc_load_en;
  logic                    pc_inc_en;
  logic                    pc_add_en;
  logic [PC_W-1:0]         pc_value;

  logic                    strobe_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    taken_o;

  // A start pulse only counts as a branch when the opcode field matches.
  assign br_hit = bus.start && (bus.instruction[OPC_HI:OPC_LO] == BR_OPCODE);

  // Next-state logic, output decode and PC request gating for the branch FSM.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    offset_d     = offset_q;
    taken_d      = taken_q;
    pc_load_en   = 1'b0;
    pc_inc_en    = 1'b0;
    pc_add_en    = 1'b0;
    strobe_o     = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    taken_o      = taken_q;

    case (state_q)
      ST_IDLE: begin
        busy_o     = 1'b0;
        // Fetch and jump requests land in the same cycle as a branch start.
        // The later offset add therefore sees the updated PC.
        pc_load_en = bus.pc_load;
        pc_inc_en  = bus.pc_inc;
        if (br_hit) begin
          // Latch the offset now; later IR changes must not affect this branch.
          offset_d = PC_W'(sext_c2(bus.instruction[C2_HI:C2_LO]));
          state_d  = ST_STROBE;
        end
      end

      ST_STROBE: begin
        strobe_o     = 1'b1;
        settle_cnt_d = SETTLE_INIT;
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_RESOLVE;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_CNT_W'(1);
        end
      end

      ST_RESOLVE: begin
        // taken follows con_in here so that it is valid together with done.
        // It then holds this value until the next resolve.
        done_o    = 1'b1;
        taken_o   = bus.con_in;
        taken_d   = bus.con_in;
        pc_add_en = bus.con_in;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, settle counter, latched offset and taken flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      offset_q     <= '0;
      taken_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      offset_q     <= offset_d;
      taken_q      <= taken_d;
    end
  end

  branch_pc_sequencer_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (reset),
    .load       (pc_load_en),
    .inc        (pc_inc_en),
    .add_en     (pc_add_en),
    .load_value (bus.pc_load_value),
    .add_value  (offset_q),
    .pc         (pc_value)
  );

  assign bus.con_strobe = strobe_o;
  assign bus.pc_out     = pc_value;
  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.taken      = taken_o;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Testbench for branch_pc_sequencer.
// Two instances are driven with the same stimulus: CON_SETTLE=1 and CON_SETTLE=4.
// Each instance has a timeline reference model. The driver pushes the expected
// results into queues, and a separate monitor pops and compares them.
module tb_branch_pc_sequencer;

  localparam logic [4:0] BR = 5'b10010;

  logic        clk;
  logic        rst_n;
  logic        d_start;
  logic [31:0] d_instr;
  logic        d_con;
  logic        d_inc;
  logic        d_load;
  logic [31:0] d_ldv;

  branch_pc_sequencer_if #(.PC_W(32)) if_a ();
  branch_pc_sequencer_if #(.PC_W(32)) if_b ();

  assign if_a.start         = d_start;
  assign if_a.instruction   = d_instr;
  assign if_a.con_in        = d_con;
  assign if_a.pc_inc        = d_inc;
  assign if_a.pc_load       = d_load;
  assign if_a.pc_load_value = d_ldv;
  assign if_b.start         = d_start;
  assign if_b.instruction   = d_instr;
  assign if_b.con_in        = d_con;
  assign if_b.pc_inc        = d_inc;
  assign if_b.pc_load       = d_load;
  assign if_b.pc_load_value = d_ldv;

  branch_pc_sequencer #(
    .PC_W(32), .RESET_PC(32'h0), .BR_OPCODE(BR), .CON_SETTLE(1)
  ) dut_a (
    .clk(clk), .reset(rst_n), .bus(if_a)
  );

  branch_pc_sequencer #(
    .PC_W(32), .RESET_PC(32'h0), .BR_OPCODE(BR), .CON_SETTLE(4)
  ) dut_b (
    .clk(clk), .reset(rst_n), .bus(if_b)
  );

  logic        obs_strobe [2];
  logic        obs_busy   [2];
  logic        obs_done   [2];
  logic        obs_taken  [2];
  logic [31:0] obs_pc     [2];

  assign obs_strobe[0] = if_a.con_strobe;
  assign obs_busy[0]   = if_a.busy;
  assign obs_done[0]   = if_a.done;
  assign obs_taken[0]  = if_a.taken;
  assign obs_pc[0]     = if_a.pc_out;
  assign obs_strobe[1] = if_b.con_strobe;
  assign obs_busy[1]   = if_b.busy;
  assign obs_done[1]   = if_b.done;
  assign obs_taken[1]  = if_b.taken;
  assign obs_pc[1]     = if_b.pc_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard types and queues.
  typedef struct {
    int          cyc;
    bit          busy;
    logic [31:0] pc;
    bit          taken;
  } cyc_exp_t;

  typedef struct {
    int cyc;
    bit taken;
  } done_exp_t;

  cyc_exp_t  cyc_q    [2][$];
  int        strobe_q [2][$];
  done_exp_t done_q   [2][$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state, one entry per DUT.
  logic [31:0] m_pc         [2];
  bit          m_active     [2];
  int          m_resolve_at [2];
  logic [31:0] m_off        [2];
  bit          m_taken      [2];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mk_ins(input logic [4:0] op, input logic [18:0] c2);
    return {op, 8'h00, c2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model step for one DUT in the current cycle.
  // The rules are:
  //  - reset clears everything;
  //  - the cycle 2+S after an accepted start resolves the branch;
  //  - a branch is busy from start+1 up to and including its resolve cycle;
  //  - when not busy, load or inc updates the PC and a matching start opens a branch.
  task automatic model_step(input int d);
    cyc_exp_t    e;
    done_exp_t   de;
    logic [18:0] c2;
    e.cyc = cyc;
    if (!rst_n) begin
      m_pc[d]     = 32'h0;
      m_active[d] = 1'b0;
      m_taken[d]  = 1'b0;
      strobe_q[d].delete();
      done_q[d].delete();
      e.busy  = 1'b0;
      e.pc    = 32'h0;
      e.taken = 1'b0;
      cyc_q[d].push_back(e);
      return;
    end
    e.busy  = m_active[d];
    e.pc    = m_pc[d];
    e.taken = m_taken[d];
    if (m_active[d] && cyc == m_resolve_at[d]) begin
      e.taken    = d_con;
      m_taken[d] = d_con;
      if (d_con) m_pc[d] = m_pc[d] + m_off[d];
      m_active[d] = 1'b0;
      de.cyc   = cyc;
      de.taken = d_con;
      done_q[d].push_back(de);
    end else if (!m_active[d]) begin
      if (d_load) m_pc[d] = d_ldv;
      else if (d_inc) m_pc[d] = m_pc[d] + 32'd1;
      if (d_start && d_instr[31:27] == BR) begin
        c2 = d_instr[18:0];
        m_active[d]     = 1'b1;
        m_off[d]        = {{13{c2[18]}}, c2};
        m_resolve_at[d] = cyc + 2 + settle_of(d);
        strobe_q[d].push_back(cyc + 1);
      end
    end
    cyc_q[d].push_back(e);
  endtask

  // Apply one cycle of stimulus at the falling edge and record expectations.
  task automatic step(input bit rn, input bit st, input logic [31:0] ins, input bit ci,
                      input bit inc, input bit ld, input logic [31:0] ldv);
    @(negedge clk);
    rst_n   = rn;
    d_start = st;
    d_instr = ins;
    d_con   = ci;
    d_inc   = inc;
    d_load  = ld;
    d_ldv   = ldv;
    for (int d = 0; d < 2; d++) model_step(d);
    cyc++;
  endtask

  task automatic idle(input int n, input bit ci);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, ci, 0, 0, 32'h0);
  endtask

  // Monitor: compare each DUT against the queued expectations for this cycle.
  task automatic check_dut(input int d);
    cyc_exp_t  e;
    done_exp_t de;
    bit        exp_strobe;
    bit        exp_done;
    while (cyc_q[d].size() > 0) begin
      e = cyc_q[d].pop_front();
      chk($sformatf("pc_out[%0d]", d), obs_pc[d], e.pc);
      chk($sformatf("busy[%0d]", d), 32'(obs_busy[d]), 32'(e.busy));
      chk($sformatf("taken[%0d]", d), 32'(obs_taken[d]), 32'(e.taken));
      exp_strobe = (strobe_q[d].size() > 0) && (strobe_q[d][0] == e.cyc);
      chk($sformatf("con_strobe[%0d]", d), 32'(obs_strobe[d]), 32'(exp_strobe));
      if (exp_strobe) void'(strobe_q[d].pop_front());
      exp_done = (done_q[d].size() > 0) && (done_q[d][0].cyc == e.cyc);
      chk($sformatf("done[%0d]", d), 32'(obs_done[d]), 32'(exp_done));
      if (exp_done) begin
        de = done_q[d].pop_front();
        chk($sformatf("done_taken[%0d]", d), 32'(obs_taken[d]), 32'(de.taken));
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) check_dut(d);
    end
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] ins;
    rst_n   = 1'b0;
    d_start = 1'b0;
    d_instr = 32'h0;
    d_con   = 1'b0;
    d_inc   = 1'b0;
    d_load  = 1'b0;
    d_ldv   = 32'h0;

    // Reset for two cycles, then release.
    step(0, 0, 32'h0, 0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 0, 32'h0);
    idle(1, 0);

    // Five increments, then a load that beats a simultaneous increment.
    for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 0, 1, 0, 32'h0);
    step(1, 0, 32'h0, 0, 1, 1, 32'h100);
    idle(2, 0);

    // Taken branch with a forward offset: 0x100 + 0x10.
    step(1, 1, mk_ins(BR, 19'h10), 1, 0, 0, 32'h0);
    idle(8, 1);

    // Negative offset (-4): first not taken, then taken.
    step(1, 0, 32'h0, 0, 0, 1, 32'h100);
    step(1, 1, mk_ins(BR, 19'h7FFFC), 0, 0, 0, 32'h0);
    idle(8, 0);
    step(1, 0, 32'h0, 1, 0, 1, 32'h100);
    step(1, 1, mk_ins(BR, 19'h7FFFC), 1, 0, 0, 32'h0);
    idle(8, 1);

    // Wraparound; a second start and an increment while busy are both ignored.
    step(1, 0, 32'h0, 1, 0, 1, 32'hFFFF_FFFF);
    step(1, 1, mk_ins(BR, 19'h1), 1, 0, 0, 32'h0);
    idle(1, 1);
    step(1, 1, mk_ins(BR, 19'h40), 1, 1, 0, 32'h0);
    idle(8, 1);

    // Increment in the same cycle as start: the branch adds to the updated PC.
    step(1, 1, mk_ins(BR, 19'h8), 1, 1, 0, 32'h0);
    idle(8, 1);

    // Reset during SETTLE aborts the branch.
    step(1, 0, 32'h0, 1, 0, 1, 32'h50);
    step(1, 1, mk_ins(BR, 19'h20), 1, 0, 0, 32'h0);
    idle(1, 1);
    step(0, 0, 32'h0, 1, 0, 0, 32'h0);
    idle(8, 1);

    // A start with a non-branch opcode produces no strobe and no busy.
    step(1, 1, mk_ins(5'b00001, 19'h10), 1, 0, 0, 32'h0);
    idle(4, 1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      op  = ($urandom_range(0, 1) == 1) ? BR : 5'($urandom);
      ins = {op, 8'($urandom), 19'($urandom)};
      step(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 3) == 0),
           ins,
           1'($urandom),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom);
    end
    idle(10, 0);

    // Any branch still pending at this point never signalled done.
    @(negedge clk);
    #4;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pending_done[%0d]", d), 32'(done_q[d].size()), 32'd0);
      chk($sformatf("pending_strobe[%0d]", d), 32'(strobe_q[d].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
